// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encoding, digit/sample widths and
// the two-digit BCD increment used by the lap timer.
package stopwatch_pkg;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRun   = 2'd1,
      StPause = 2'd2
   } state_e;

   localparam int unsigned DigitW  = 4;
   localparam int unsigned SampleW = 8;

   // Units 9 carries into tens; 99 wraps to 00.
   function automatic logic [SampleW-1:0] bcd_inc(input logic [SampleW-1:0] t);
      logic [DigitW-1:0] units;
      logic [DigitW-1:0] tens;
      units = t[DigitW-1:0];
      tens  = t[SampleW-1:DigitW];
      if (units >= 4'd9) begin
         units = '0;
         tens  = (tens >= 4'd9) ? '0 : tens + 4'd1;
      end else begin
         units = units + 4'd1;
      end
      return {tens, units};
   endfunction

endpackage

// File: rtl/btn_debounce.sv
// One button path: 2-FF synchronizer, counting debouncer and a registered
// one-cycle pulse on the rising edge of the debounced level.
module btn_debounce #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic btn_raw,
   output logic press
);

   localparam int unsigned CntW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
   localparam logic [CntW-1:0] CntMax = CntW'(DEBOUNCE_CYCLES - 1);

   logic            sync1_q, sync2_q;
   logic            level_q, level_d;
   logic            prev_q;
   logic            press_q;
   logic [CntW-1:0] cnt_q, cnt_d;

   // Any cycle where the synchronized input agrees with the level restarts the count.
   always_comb begin
      level_d = level_q;
      cnt_d   = '0;
      if (sync2_q != level_q) begin
         if (cnt_q == CntMax) begin
            level_d = sync2_q;
         end else begin
            cnt_d = cnt_q + 1'b1;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         sync1_q <= 1'b0;
         sync2_q <= 1'b0;
         level_q <= 1'b0;
         cnt_q   <= '0;
         prev_q  <= 1'b0;
         press_q <= 1'b0;
      end else begin
         sync1_q <= btn_raw;
         sync2_q <= sync1_q;
         level_q <= level_d;
         cnt_q   <= cnt_d;
         prev_q  <= level_q;
         press_q <= level_q & ~prev_q;
      end
   end

   assign press = press_q;

endmodule

// File: rtl/lap_timer.sv
// Stopwatch front end: debounced buttons, start/pause/clear FSM, BCD seconds
// counter, lap capture strobe and browse strobe for the sample stash.
module lap_timer
   import stopwatch_pkg::*;
#(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned TICKS_PER_UNIT  = 100_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               btn_start,
   input  logic               btn_lap,
   input  logic               btn_next,
   output logic [SampleW-1:0] time_bcd,
   output logic [SampleW-1:0] sample_in,
   output logic               sample_in_valid,
   output logic               next_sample,
   output logic               running
);

   localparam int unsigned PrescW = $clog2(TICKS_PER_UNIT);
   localparam logic [PrescW-1:0] PrescMax = PrescW'(TICKS_PER_UNIT - 1);

   logic start_p, lap_p, next_p;

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_start (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_start),
      .press   (start_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_lap (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_lap),
      .press   (lap_p)
   );

   btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_next (
      .clk     (clk),
      .reset   (reset),
      .btn_raw (btn_next),
      .press   (next_p)
   );

   state_e             state_q;
   logic [PrescW-1:0]  presc_q;
   logic [SampleW-1:0] time_q;
   logic [SampleW-1:0] sample_q;
   logic               valid_q;
   logic               next_q;
   logic               pend_q;
   logic               running_q;

   logic capture, next_req, tick;

   // Start beats lap in the same cycle, so a capture needs lap without start.
   assign capture  = (state_q == StRun) & lap_p & ~start_p;
   assign next_req = next_p | pend_q;
   assign tick     = (state_q == StRun) && (presc_q == PrescMax);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q   <= StIdle;
         presc_q   <= '0;
         time_q    <= '0;
         sample_q  <= '0;
         valid_q   <= 1'b0;
         next_q    <= 1'b0;
         pend_q    <= 1'b0;
         running_q <= 1'b0;
      end else begin
         valid_q <= capture;
         if (capture) begin
            sample_q <= time_q;
         end
         // The stash ignores a browse while it writes, so hold it back one cycle.
         if (next_req && capture) begin
            pend_q <= 1'b1;
            next_q <= 1'b0;
         end else begin
            pend_q <= 1'b0;
            next_q <= next_req;
         end
         unique case (state_q)
            StIdle: begin
               presc_q <= '0;
               time_q  <= '0;
               if (start_p) begin
                  state_q   <= StRun;
                  running_q <= 1'b1;
               end
            end
            StRun: begin
               if (tick) begin
                  presc_q <= '0;
                  time_q  <= bcd_inc(time_q);
               end else begin
                  presc_q <= presc_q + 1'b1;
               end
               if (start_p) begin
                  state_q   <= StPause;
                  running_q <= 1'b0;
               end
            end
            StPause: begin
               if (start_p) begin
                  state_q   <= StRun;
                  running_q <= 1'b1;
               end else if (lap_p) begin
                  state_q <= StIdle;
                  presc_q <= '0;
                  time_q  <= '0;
               end
            end
            default: begin
               state_q   <= StIdle;
               running_q <= 1'b0;
            end
         endcase
      end
   end

   assign time_bcd        = time_q;
   assign sample_in       = sample_q;
   assign sample_in_valid = valid_q;
   assign next_sample     = next_q;
   assign running         = running_q;

endmodule

// File: tb/tb_lap_timer.sv
// Self-checking bench for lap_timer: event-level stopwatch model, capture/browse
// scoreboard queues and a table of button-press rows.
module tb_lap_timer;

   localparam int Deb = 4;
   localparam int Tpu = 3;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       btn_start = 1'b0;
   logic       btn_lap = 1'b0;
   logic       btn_next = 1'b0;
   logic [7:0] time_bcd, sample_in;
   logic       sample_in_valid, next_sample, running;

   lap_timer #(.DEBOUNCE_CYCLES(Deb), .TICKS_PER_UNIT(Tpu)) dut (
      .clk             (clk),
      .reset           (reset),
      .btn_start       (btn_start),
      .btn_lap         (btn_lap),
      .btn_next        (btn_next),
      .time_bcd        (time_bcd),
      .sample_in       (sample_in),
      .sample_in_valid (sample_in_valid),
      .next_sample     (next_sample),
      .running         (running)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int failures = 0;

   typedef struct {
      logic [7:0] val;
      int         at;
   } ev_t;

   ev_t cap_q[$];
   int  nxt_q[$];
   ev_t cap_pop;
   int  nxt_pop;

   // Event-level model: RUN cycles accumulate; time = count / Tpu.
   typedef enum {MIdle, MRun, MPause} mstate_e;
   mstate_e mst = MIdle;
   int acc = 0;
   int e_run = 0;
   int e_base;
   int l_cap;

   typedef struct {
      logic [2:0] mask;  // {next, lap, start}
      logic       exp_run;
      logic       exp_cap;
      logic       exp_next;
   } row_t;
   row_t rows[10];

   function automatic logic [7:0] to_bcd(input int n);
      int v;
      v = n % 100;
      return {4'(v / 10), 4'(v % 10)};
   endfunction

   function automatic logic [7:0] exp_time(input int n);
      int c;
      c = (mst == MRun) ? acc + n - e_run : acc;
      return to_bcd(c / Tpu);
   endfunction

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s: got %0h required %0h (cycle %0d)", name, got, exp, cyc);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic step_chk();
      step();
      chk("time_bcd", time_bcd, exp_time(cyc));
      chk("running", running, mst == MRun);
      chk("bcd_digits", (time_bcd[3:0] > 4'd9) || (time_bcd[7:4] > 4'd9), 0);
   endtask

   task automatic wait_to(input int target);
      while (cyc < target) step_chk();
   endtask

   // Raise buttons, return on the edge where the FSM acts on the pulse.
   task automatic press_hold(input logic [2:0] mask);
      int  l;
      bit  cap;
      {btn_next, btn_lap, btn_start} = mask;
      repeat (Deb + 3) step_chk();
      step();
      l   = cyc;
      cap = 0;
      if (mask[0]) begin
         if (mst == MRun) begin
            acc = acc + l - e_run;
            mst = MPause;
         end else begin
            mst   = MRun;
            e_run = l;
         end
      end else if (mask[1]) begin
         if (mst == MRun) begin
            cap_q.push_back('{val: exp_time(l - 1), at: l});
            cap = 1;
         end else if (mst == MPause) begin
            mst = MIdle;
            acc = 0;
         end
      end
      if (mask[2]) nxt_q.push_back(cap ? l + 1 : l);
      chk("press_running", running, mst == MRun);
      chk("press_time", time_bcd, exp_time(l));
   endtask

   task automatic release_btns();
      {btn_next, btn_lap, btn_start} = 3'b000;
      repeat (8) step_chk();
   endtask

   always @(negedge clk) begin
      if (sample_in_valid) begin
         if (cap_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_capture: sample_in_valid=1 required 0 (cycle %0d)", cyc);
         end else begin
            cap_pop = cap_q.pop_front();
            chk("capture_value", sample_in, cap_pop.val);
            chk("capture_cycle", cyc, cap_pop.at);
         end
      end
      if (next_sample) begin
         if (nxt_q.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_next: next_sample=1 required 0 (cycle %0d)", cyc);
         end else begin
            nxt_pop = nxt_q.pop_front();
            chk("next_cycle", cyc, nxt_pop);
         end
      end
   end

   initial begin
      rows[0] = '{mask: 3'b010, exp_run: 1'b0, exp_cap: 1'b0, exp_next: 1'b0};
      rows[1] = '{mask: 3'b100, exp_run: 1'b0, exp_cap: 1'b0, exp_next: 1'b1};
      rows[2] = '{mask: 3'b001, exp_run: 1'b1, exp_cap: 1'b0, exp_next: 1'b0};
      rows[3] = '{mask: 3'b010, exp_run: 1'b1, exp_cap: 1'b1, exp_next: 1'b0};
      rows[4] = '{mask: 3'b011, exp_run: 1'b0, exp_cap: 1'b0, exp_next: 1'b0};
      rows[5] = '{mask: 3'b100, exp_run: 1'b0, exp_cap: 1'b0, exp_next: 1'b1};
      rows[6] = '{mask: 3'b001, exp_run: 1'b1, exp_cap: 1'b0, exp_next: 1'b0};
      rows[7] = '{mask: 3'b110, exp_run: 1'b1, exp_cap: 1'b1, exp_next: 1'b1};
      rows[8] = '{mask: 3'b001, exp_run: 1'b0, exp_cap: 1'b0, exp_next: 1'b0};
      rows[9] = '{mask: 3'b010, exp_run: 1'b0, exp_cap: 1'b0, exp_next: 1'b0};

      // Reset values
      repeat (3) step();
      chk("rst_time", time_bcd, 8'h00);
      chk("rst_sample", sample_in, 8'h00);
      chk("rst_valid", sample_in_valid, 0);
      chk("rst_next", next_sample, 0);
      chk("rst_running", running, 0);
      reset = 1'b0;
      step_chk();

      // Bounce on start, then hold: running must rise 8 edges after the last edge
      for (int i = 0; i < 10; i++) begin
         btn_start = ~btn_start;
         repeat (2) step_chk();
      end
      press_hold(3'b001);
      chk("bounce_start_run", running, 1);
      e_base = e_run;
      release_btns();

      // Count and wrap
      wait_to(e_base + 299);
      chk("time_99", time_bcd, 8'h99);
      step_chk();
      chk("time_wrap_00", time_bcd, 8'h00);

      // Lap mid-phase at 27
      wait_to(e_base + 375);
      press_hold(3'b010);
      chk("lap27_valid", sample_in_valid, 1);
      chk("lap27_sample", sample_in, 8'h27);
      chk("lap27_running", running, 1);
      release_btns();

      // Lap aligned with the 27->28 tick
      wait_to(e_base + 676);
      press_hold(3'b010);
      chk("lap_tick_sample", sample_in, 8'h27);
      chk("lap_tick_time", time_bcd, 8'h28);
      release_btns();

      // Pause at 15, frozen, resume on held prescaler phase
      wait_to(e_base + 938);
      press_hold(3'b001);
      chk("pause_time", time_bcd, 8'h15);
      chk("pause_running", running, 0);
      release_btns();
      repeat (50) begin
         step_chk();
         chk("frozen_15", time_bcd, 8'h15);
      end
      press_hold(3'b001);
      chk("resume_running", running, 1);
      step_chk();
      chk("resume_hold_15", time_bcd, 8'h15);
      step_chk();
      chk("resume_tick_16", time_bcd, 8'h16);
      release_btns();

      // Pause then lap clears to IDLE with no capture
      press_hold(3'b001);
      release_btns();
      press_hold(3'b010);
      chk("clear_time", time_bcd, 8'h00);
      chk("clear_running", running, 0);
      chk("clear_no_capture", sample_in_valid, 0);
      release_btns();

      // Table-driven press rows
      for (int r = 0; r < 10; r++) begin
         press_hold(rows[r].mask);
         chk("row_running", running, rows[r].exp_run);
         chk("row_capture", sample_in_valid, rows[r].exp_cap);
         chk("row_next_now", next_sample, rows[r].exp_next && !rows[r].exp_cap);
         step_chk();
         chk("row_next_late", next_sample, rows[r].exp_next && rows[r].exp_cap);
         chk("row_capture_gone", sample_in_valid, 0);
         release_btns();
      end
      chk("table_idle_time", time_bcd, 8'h00);

      // Reset mid-RUN at 42 with a deferred next pending
      press_hold(3'b001);
      l_cap = e_run + 127;
      release_btns();
      wait_to(l_cap - 8);
      press_hold(3'b110);
      chk("rst42_sample", sample_in, 8'h42);
      chk("rst42_time", time_bcd, 8'h42);
      nxt_q.delete();
      reset = 1'b1;
      {btn_next, btn_lap, btn_start} = 3'b000;
      step();
      mst = MIdle;
      acc = 0;
      chk("midrst_time", time_bcd, 8'h00);
      chk("midrst_sample", sample_in, 8'h00);
      chk("midrst_valid", sample_in_valid, 0);
      chk("midrst_next", next_sample, 0);
      chk("midrst_running", running, 0);
      step();
      reset = 1'b0;
      repeat (20) step_chk();

      chk("captures_drained", cap_q.size(), 0);
      chk("nexts_drained", nxt_q.size(), 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
